// File: rtl/fifo_sram_reader_if.sv
// rtl/fifo_sram_reader_if.sv - FIFO read port and downstream stream bundle for fifo_sram_reader
// Purpose: groups the FIFO-side pop/data/empty signals with the downstream
//   valid/ready/data stream. Signal suffixes are from the reader's viewpoint.
// Signals:
//   fifo_empty_i  FIFO empty flag (registered inside the FIFO)
//   fifo_pop_o    pop request to the FIFO
//   fifo_data_i   FIFO read data, valid RD_LATENCY cycles after a pop
//   valid_o       downstream word available
//   ready_i       downstream accepts the word
//   data_o        head word of the skid buffer
// Modports: master = the reader, slave = FIFO plus downstream consumer.

interface fifo_sram_reader_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  fifo_empty_i;
  logic                  fifo_pop_o;
  logic [DATA_WIDTH-1:0] fifo_data_i;
  logic                  valid_o;
  logic                  ready_i;
  logic [DATA_WIDTH-1:0] data_o;

  modport master (
    input  fifo_empty_i, fifo_data_i, ready_i,
    output fifo_pop_o, valid_o, data_o
  );

  modport slave (
    output fifo_empty_i, fifo_data_i, ready_i,
    input  fifo_pop_o, valid_o, data_o
  );
endinterface

// File: rtl/fifo_sram_reader.sv
// rtl/fifo_sram_reader.sv - read-side drain engine for the SRAM-backed FIFO
// Purpose: pops the FIFO against its fixed read latency, lands the returned
//   words in a small circular skid buffer and presents them downstream as a
//   valid/ready stream. Pops are limited by credit (buffered + in-flight words),
//   so ready_i never reaches fifo_pop_o combinationally.
// Ports:
//   clk_i          clock, all state on posedge
//   rst_i          asynchronous active-high reset
//   flush_i        drop all buffered and in-flight words
//   bus            fifo_sram_reader_if.master: FIFO pop/data/empty + stream
//   occupancy_o    number of words currently buffered
//   drained_cnt_o  delivered-word counter, tied to 0 unless enabled
// Optional feature macro: FIFO_SRAM_READER_STATS_EN (drained_cnt_o counter)

module fifo_sram_reader #(
  parameter  int DATA_WIDTH = 32,
  parameter  int RD_LATENCY = 1,
  parameter  int BUF_DEPTH  = RD_LATENCY + 2,
  localparam int OCC_W      = $clog2(BUF_DEPTH + 1),
  localparam int PTR_W      = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               flush_i,
  fifo_sram_reader_if.master bus,
  output logic [OCC_W-1:0]   occupancy_o,
  output logic [31:0]        drained_cnt_o
);

  // Two spare bits cover occupancy plus up to three in-flight reads.
  localparam int CRED_W = OCC_W + 2;

  logic [RD_LATENCY-1:0] inflight_q, inflight_d;
  logic [OCC_W-1:0]      occ_q, occ_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [DATA_WIDTH-1:0] mem_q [BUF_DEPTH];

  logic                  pop;
  logic                  arrive;
  logic                  handshake;
  logic [CRED_W-1:0]     credit_used;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(BUF_DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // Credit: a pop is only issued if its word is guaranteed a free slot,
  // counting every read that is still travelling through the FIFO pipeline.
  always_comb begin
    credit_used = CRED_W'(occ_q);
    for (int i = 0; i < RD_LATENCY; i++) begin
      credit_used = credit_used + CRED_W'(inflight_q[i]);
    end
    pop = !rst_i && !flush_i && !bus.fifo_empty_i &&
          (credit_used < CRED_W'(BUF_DEPTH));
  end

  // The oldest in-flight bit marks the cycle fifo_data_i carries a word;
  // during a flush that word belongs to the discarded stream.
  assign arrive    = inflight_q[RD_LATENCY-1] && !flush_i;
  assign handshake = bus.valid_o && bus.ready_i;

  assign bus.fifo_pop_o = pop;
  assign bus.valid_o    = (occ_q != '0);
  assign bus.data_o     = mem_q[rd_ptr_q];
  assign occupancy_o    = occ_q;

  always_comb begin
    inflight_d = '0;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    occ_d      = occ_q + OCC_W'(arrive) - OCC_W'(handshake);

    if (handshake) begin
      rd_ptr_d = ptr_inc(rd_ptr_q);
    end
    if (arrive) begin
      wr_ptr_d = ptr_inc(wr_ptr_q);
    end

    if (flush_i) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      occ_d    = '0;
    end else begin
      inflight_d[0] = pop;
      for (int i = 1; i < RD_LATENCY; i++) begin
        inflight_d[i] = inflight_q[i-1];
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      inflight_q <= '0;
      occ_q      <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      for (int i = 0; i < BUF_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      inflight_q <= inflight_d;
      occ_q      <= occ_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      if (arrive) begin
        mem_q[wr_ptr_q] <= bus.fifo_data_i;
      end
    end
  end

`ifdef FIFO_SRAM_READER_STATS_EN
  // Counts every handshake, including one in a flush cycle; only reset clears it.
  logic [31:0] drained_cnt_q, drained_cnt_d;

  always_comb begin
    drained_cnt_d = drained_cnt_q;
    if (handshake) begin
      drained_cnt_d = drained_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      drained_cnt_q <= '0;
    end else begin
      drained_cnt_q <= drained_cnt_d;
    end
  end

  assign drained_cnt_o = drained_cnt_q;
`else
  assign drained_cnt_o = '0;
`endif

endmodule

// File: tb/tb_fifo_sram_reader.sv
// tb/tb_fifo_sram_reader.sv - self-checking bench for fifo_sram_reader

module tb_fifo_sram_reader;
  localparam int DW    = 32;
  localparam int L     = 2;
  localparam int D     = 4;
  localparam int OCC_W = $clog2(D + 1);
`ifdef FIFO_SRAM_READER_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic             clk;
  logic             rst;
  logic             flush;
  logic [OCC_W-1:0] occupancy;
  logic [31:0]      drained_cnt;

  fifo_sram_reader_if #(.DATA_WIDTH(DW)) bus ();

  fifo_sram_reader #(
    .DATA_WIDTH(DW),
    .RD_LATENCY(L),
    .BUF_DEPTH (D)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .flush_i      (flush),
    .bus          (bus.master),
    .occupancy_o  (occupancy),
    .drained_cnt_o(drained_cnt)
  );

  int vectors     = 0;
  int miscompares = 0;

  // FIFO contents, FIFO read pipeline, and the reader's expected state:
  // landed_q is the buffer contents in delivery order, mv marks reads the
  // reader still owes a slot to (cleared by flush/reset).
  logic [DW-1:0] fifo_q[$];
  logic [DW-1:0] landed_q[$];
  bit            fv[L];
  logic [DW-1:0] fd[L];
  bit            mv[L];
  int            cnt_m = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk or posedge rst) begin : model
    logic [DW-1:0] w, lword;
    bit pop, hs, land;
    if (rst) begin
      landed_q.delete();
      for (int i = 0; i < L; i++) begin
        fv[i] = 1'b0;
        mv[i] = 1'b0;
      end
      cnt_m = 0;
      bus.fifo_empty_i <= (fifo_q.size() == 0);
      bus.fifo_data_i  <= DW'($urandom);
    end else begin
      pop   = bus.fifo_pop_o;
      hs    = bus.valid_o && bus.ready_i;
      land  = mv[L-1];
      lword = fd[L-1];
      if (hs) cnt_m++;
      w = DW'($urandom);
      if (pop) begin
        vectors++;
        if (fifo_q.size() == 0) begin
          miscompares++;
          $display("FAIL pop_on_empty: fifo_pop_o=1 required 0 (FIFO empty)");
        end else begin
          w = fifo_q.pop_front();
        end
      end
      for (int i = L - 1; i > 0; i--) begin
        fv[i] = fv[i-1];
        fd[i] = fd[i-1];
        mv[i] = mv[i-1];
      end
      fv[0] = pop;
      fd[0] = w;
      mv[0] = pop;
      if (flush) fifo_q.delete();
      bus.fifo_empty_i <= (fifo_q.size() == 0);
      bus.fifo_data_i  <= fv[L-1] ? fd[L-1] : DW'($urandom);
      if (hs) void'(landed_q.pop_front());
      if (flush) begin
        landed_q.delete();
        for (int i = 0; i < L; i++) mv[i] = 1'b0;
      end else if (land) begin
        vectors++;
        if (landed_q.size() >= D) begin
          miscompares++;
          $display("FAIL arrive_full: buffered=%0d required <%0d at arrival", landed_q.size(), D);
        end
        landed_q.push_back(lword);
      end
    end
  end

  always @(negedge clk) begin : monitor
    int  infl;
    bit  exp_pop;
    logic [31:0] exp_cnt;
    #2;
    if (!rst) begin
      infl = 0;
      for (int i = 0; i < L; i++) infl += int'(mv[i]);
      exp_pop = !flush && !bus.fifo_empty_i && (landed_q.size() + infl < D);
      exp_cnt = STATS ? 32'(cnt_m) : 32'd0;
      vectors++;
      if (bus.valid_o !== (landed_q.size() != 0)) begin
        miscompares++;
        $display("FAIL mon_valid: got %b required %b", bus.valid_o, landed_q.size() != 0);
      end
      vectors++;
      if (occupancy !== OCC_W'(landed_q.size())) begin
        miscompares++;
        $display("FAIL mon_occupancy: got %0d required %0d", occupancy, landed_q.size());
      end
      if (landed_q.size() != 0) begin
        vectors++;
        if (bus.data_o !== landed_q[0]) begin
          miscompares++;
          $display("FAIL mon_data: got %h required %h", bus.data_o, landed_q[0]);
        end
      end
      vectors++;
      if (bus.fifo_pop_o !== exp_pop) begin
        miscompares++;
        $display("FAIL mon_pop: got %b required %b", bus.fifo_pop_o, exp_pop);
      end
      vectors++;
      if (drained_cnt !== exp_cnt) begin
        miscompares++;
        $display("FAIL mon_drained_cnt: got %0d required %0d", drained_cnt, exp_cnt);
      end
    end
  end

  task automatic do_reset();
    rst = 1'b1;
    flush = 1'b0;
    bus.ready_i = 1'b0;
    fifo_q.delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    flush = 1'b0;
    bus.ready_i = 1'b1;
    fifo_q.delete();
    fifo_q.push_back(32'h1111_0000);
    fifo_q.push_back(32'h1111_0001);
    repeat (3) @(negedge clk);
    #2;
    vectors++;
    if (bus.valid_o !== 1'b0) begin miscompares++; $display("FAIL reset_valid: got %b required 0", bus.valid_o); end
    vectors++;
    if (bus.fifo_pop_o !== 1'b0) begin miscompares++; $display("FAIL reset_pop: got %b required 0", bus.fifo_pop_o); end
    vectors++;
    if (bus.data_o !== '0) begin miscompares++; $display("FAIL reset_data: got %h required 0", bus.data_o); end
    vectors++;
    if (occupancy !== '0) begin miscompares++; $display("FAIL reset_occupancy: got %0d required 0", occupancy); end
    vectors++;
    if (drained_cnt !== 32'd0) begin miscompares++; $display("FAIL reset_drained_cnt: got %0d required 0", drained_cnt); end
    @(negedge clk);
    rst = 1'b0;
    repeat (10) @(negedge clk);
  endtask

  task automatic test_latency();
    bit          pop_s[8];
    bit          val_s[8];
    logic [DW-1:0] dat_s[8];
    @(negedge clk);
    bus.ready_i = 1'b1;
    fifo_q.push_back(32'hA0);
    fifo_q.push_back(32'hA1);
    fifo_q.push_back(32'hA2);
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      #3;
      pop_s[c] = bus.fifo_pop_o;
      val_s[c] = bus.valid_o;
      dat_s[c] = bus.data_o;
    end
    for (int c = 0; c < 8; c++) begin
      vectors++;
      if (pop_s[c] !== (c < 3)) begin
        miscompares++;
        $display("FAIL latency_pop[%0d]: got %b required %b", c, pop_s[c], c < 3);
      end
      vectors++;
      if (val_s[c] !== (c >= L + 1 && c < L + 4)) begin
        miscompares++;
        $display("FAIL latency_valid[%0d]: got %b required %b", c, val_s[c], c >= L + 1 && c < L + 4);
      end
      if (c >= L + 1 && c < L + 4) begin
        vectors++;
        if (dat_s[c] !== 32'hA0 + 32'(c - (L + 1))) begin
          miscompares++;
          $display("FAIL latency_data[%0d]: got %h required %h", c, dat_s[c], 32'hA0 + 32'(c - (L + 1)));
        end
      end
    end
  endtask

  task automatic test_backpressure();
    logic [DW-1:0] w[10];
    int npops = 0;
    @(negedge clk);
    bus.ready_i = 1'b0;
    for (int i = 0; i < 10; i++) begin
      w[i] = $urandom;
      fifo_q.push_back(w[i]);
    end
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      #3;
      if (bus.fifo_pop_o) npops++;
    end
    vectors++;
    if (npops != D) begin miscompares++; $display("FAIL bp_pops: got %0d required %0d", npops, D); end
    vectors++;
    if (occupancy !== OCC_W'(D)) begin miscompares++; $display("FAIL bp_occupancy: got %0d required %0d", occupancy, D); end
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      bus.ready_i = 1'b1;
      #3;
      vectors++;
      if (!(bus.valid_o && bus.ready_i) || bus.data_o !== w[i]) begin
        miscompares++;
        $display("FAIL bp_stream[%0d]: valid=%b data=%h required valid=1 data=%h", i, bus.valid_o, bus.data_o, w[i]);
      end
    end
    repeat (4) @(negedge clk);
  endtask

  task automatic test_simultaneous();
    logic [DW-1:0] w[3];
    bit found = 1'b0;
    @(negedge clk);
    bus.ready_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      w[i] = $urandom;
      fifo_q.push_back(w[i]);
    end
    for (int c = 0; c < 20 && !found; c++) begin
      @(negedge clk);
      #3;
      if (occupancy == OCC_W'(2) && mv[L-1]) found = 1'b1;
    end
    vectors++;
    if (!found) begin
      miscompares++;
      $display("FAIL simul_setup: occ=2 with arrival not reached, occ=%0d", occupancy);
    end else begin
      bus.ready_i = 1'b1;
      @(negedge clk);
      bus.ready_i = 1'b0;
      #3;
      vectors++;
      if (occupancy !== OCC_W'(2)) begin miscompares++; $display("FAIL simul_occupancy: got %0d required 2", occupancy); end
      vectors++;
      if (bus.data_o !== w[1]) begin miscompares++; $display("FAIL simul_data: got %h required %h", bus.data_o, w[1]); end
    end
    @(negedge clk);
    bus.ready_i = 1'b1;
    repeat (6) @(negedge clk);
  endtask

  task automatic test_flush();
    logic [DW-1:0] w[5];
    logic [DW-1:0] nw;
    bit found = 1'b0;
    bit got = 1'b0;
    int infl;
    @(negedge clk);
    bus.ready_i = 1'b0;
    for (int i = 0; i < 5; i++) begin
      w[i] = $urandom;
      fifo_q.push_back(w[i]);
    end
    for (int c = 0; c < 20 && !found; c++) begin
      @(negedge clk);
      #3;
      infl = 0;
      for (int i = 0; i < L; i++) infl += int'(mv[i]);
      if (occupancy == OCC_W'(3) && infl == 1) found = 1'b1;
    end
    vectors++;
    if (!found) begin
      miscompares++;
      $display("FAIL flush_setup: occ=3 with one in flight not reached, occ=%0d", occupancy);
    end
    flush = 1'b1;
    #1;
    vectors++;
    if (bus.fifo_pop_o !== 1'b0) begin miscompares++; $display("FAIL flush_pop: got %b required 0", bus.fifo_pop_o); end
    @(negedge clk);
    flush = 1'b0;
    #3;
    vectors++;
    if (bus.valid_o !== 1'b0) begin miscompares++; $display("FAIL flush_valid: got %b required 0", bus.valid_o); end
    vectors++;
    if (occupancy !== '0) begin miscompares++; $display("FAIL flush_occupancy: got %0d required 0", occupancy); end
    nw = 32'h5EED_0000 | 32'($urandom_range(0, 255));
    fifo_q.push_back(nw);
    bus.ready_i = 1'b1;
    for (int c = 0; c < 20 && !got; c++) begin
      @(negedge clk);
      #3;
      if (bus.valid_o && bus.ready_i) begin
        got = 1'b1;
        vectors++;
        if (bus.data_o !== nw) begin miscompares++; $display("FAIL flush_next_word: got %h required %h", bus.data_o, nw); end
      end
    end
    vectors++;
    if (!got) begin miscompares++; $display("FAIL flush_next_timeout: valid=%b required a handshake", bus.valid_o); end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset_async();
    logic [DW-1:0] first_exp;
    bit got = 1'b0;
    do_reset();
    bus.ready_i = 1'b1;
    for (int i = 0; i < 20; i++) fifo_q.push_back($urandom);
    repeat (6) @(negedge clk);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    vectors++;
    if (bus.valid_o !== 1'b0) begin miscompares++; $display("FAIL async_rst_valid: got %b required 0", bus.valid_o); end
    vectors++;
    if (bus.fifo_pop_o !== 1'b0) begin miscompares++; $display("FAIL async_rst_pop: got %b required 0", bus.fifo_pop_o); end
    vectors++;
    if (occupancy !== '0) begin miscompares++; $display("FAIL async_rst_occupancy: got %0d required 0", occupancy); end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    first_exp = fifo_q[0];
    for (int c = 0; c < 20 && !got; c++) begin
      @(negedge clk);
      #3;
      if (bus.valid_o && bus.ready_i) begin
        got = 1'b1;
        vectors++;
        if (bus.data_o !== first_exp) begin miscompares++; $display("FAIL async_rst_first: got %h required %h", bus.data_o, first_exp); end
      end
    end
    vectors++;
    if (!got) begin miscompares++; $display("FAIL async_rst_timeout: no delivery after reset release"); end
    repeat (30) @(negedge clk);
  endtask

  task automatic test_stats();
    int nhs = 0;
    logic [31:0] exp;
    do_reset();
    bus.ready_i = 1'b1;
    for (int i = 0; i < 5; i++) fifo_q.push_back($urandom);
    for (int c = 0; c < 15; c++) begin
      @(negedge clk);
      #3;
      if (bus.valid_o && bus.ready_i) nhs++;
    end
    @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    for (int i = 0; i < 3; i++) fifo_q.push_back($urandom);
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      #3;
      if (bus.valid_o && bus.ready_i) nhs++;
    end
    vectors++;
    if (nhs != 8) begin miscompares++; $display("FAIL stats_handshakes: got %0d required 8", nhs); end
    exp = STATS ? 32'd8 : 32'd0;
    vectors++;
    if (drained_cnt !== exp) begin miscompares++; $display("FAIL stats_count: got %0d required %0d", drained_cnt, exp); end
  endtask

  task automatic test_random();
    int thr = 2;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      if (c % 200 == 0) thr = $urandom_range(0, 4);
      bus.ready_i = ($urandom_range(0, 3) < thr);
      if (fifo_q.size() < 12 && $urandom_range(0, 2) != 0) fifo_q.push_back($urandom);
      flush = ($urandom_range(0, 96) == 0);
    end
    @(negedge clk);
    flush = 1'b0;
    bus.ready_i = 1'b1;
    repeat (40) @(negedge clk);
    #3;
    vectors++;
    if (bus.valid_o !== 1'b0 || landed_q.size() != 0) begin
      miscompares++;
      $display("FAIL random_drain: valid=%b buffered=%0d required 0/0", bus.valid_o, landed_q.size());
    end
  endtask

  initial begin
    rst = 1'b1;
    flush = 1'b0;
    bus.ready_i = 1'b0;
    test_reset();
    test_latency();
    test_backpressure();
    test_simultaneous();
    test_flush();
    test_reset_async();
    test_stats();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "watchdog expired");
  end

endmodule
